// File: rtl/fft_out_serializer.sv
// Captures one parallel 32-bin FFT frame and streams it out one bin per valid/ready beat.
// Define FFT_SER_PEAK_DET_EN to build the per-frame peak (max L1 magnitude) detector.
module fft_out_serializer #(
  parameter int unsigned N  = 32,
  parameter int unsigned W  = 16,
  parameter int unsigned IW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_re,
  input  logic [N*W-1:0] in_im,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IW-1:0]  out_idx,
  output logic [W-1:0]   out_re,
  output logic [W-1:0]   out_im,
  output logic [W:0]     out_mag,
  output logic           out_last,
  output logic           peak_valid,
  output logic [IW-1:0]  peak_idx,
  output logic [W:0]     peak_mag,
  output logic [7:0]     drop_cnt
);

  typedef enum logic [1:0] {StIdle, StStream, StPeak} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [W-1:0]  r_buf_re [N];
  logic [W-1:0]  r_buf_im [N];
  logic [IW-1:0] r_idx;
  logic [7:0]    r_drop_cnt;
  logic          w_capture;
  logic          w_beat;
  logic          w_last_beat;
  logic [W-1:0]  w_abs_re;
  logic [W-1:0]  w_abs_im;

  assign in_ready    = (r_state == StIdle);
  assign out_valid   = (r_state == StStream);
  assign w_capture   = in_valid && in_ready;
  assign w_beat      = out_valid && out_ready;
  assign out_last    = out_valid && (r_idx == IW'(N - 1));
  assign w_last_beat = w_beat && out_last;

  assign out_idx = r_idx;
  assign out_re  = r_buf_re[r_idx];
  assign out_im  = r_buf_im[r_idx];

  // Two's-complement negate in W bits maps -2^(W-1) onto 2^(W-1) as an unsigned value.
  assign w_abs_re = out_re[W-1] ? (~out_re + 1'b1) : out_re;
  assign w_abs_im = out_im[W-1] ? (~out_im + 1'b1) : out_im;
  assign out_mag  = {1'b0, w_abs_re} + {1'b0, w_abs_im};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (in_valid) w_state_next = StStream;
      end
      StStream: begin
`ifdef FFT_SER_PEAK_DET_EN
        if (w_last_beat) w_state_next = StPeak;
`else
        if (w_last_beat) w_state_next = StIdle;
`endif
      end
      StPeak:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_idx <= '0;
      end else if (w_beat) begin
        r_idx <= w_last_beat ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Frame buffer needs no reset; it is only read after a capture.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int k = 0; k < N; k++) begin
        r_buf_re[k] <= in_re[k*W +: W];
        r_buf_im[k] <= in_im[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (in_valid && !in_ready && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;

`ifdef FFT_SER_PEAK_DET_EN
  logic [IW-1:0] r_max_idx;
  logic [W:0]    r_max_mag;
  logic [IW-1:0] r_peak_idx;
  logic [W:0]    r_peak_mag;
  logic          w_new_max;

  // Strict compare so ties keep the earliest (lowest) bin.
  assign w_new_max = (out_mag > r_max_mag);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max_idx  <= '0;
      r_max_mag  <= '0;
      r_peak_idx <= '0;
      r_peak_mag <= '0;
    end else begin
      if (w_capture) begin
        r_max_idx <= '0;
        r_max_mag <= '0;
      end else if (w_beat && w_new_max) begin
        r_max_idx <= r_idx;
        r_max_mag <= out_mag;
      end
      if (w_last_beat) begin
        r_peak_idx <= w_new_max ? r_idx : r_max_idx;
        r_peak_mag <= w_new_max ? out_mag : r_max_mag;
      end
    end
  end

  assign peak_valid = (r_state == StPeak);
  assign peak_idx   = r_peak_idx;
  assign peak_mag   = r_peak_mag;
`else
  assign peak_valid = 1'b0;
  assign peak_idx   = '0;
  assign peak_mag   = '0;
`endif

endmodule

// File: tb/tb_fft_out_serializer.sv
// Bench for fft_out_serializer: directed table, corner sequences and random traffic
// checked against a frame-level reference model; honours FFT_SER_PEAK_DET_EN.
module tb_fft_out_serializer;
  localparam int N  = 32;
  localparam int W  = 16;
  localparam int IW = 5;
`ifdef FFT_SER_PEAK_DET_EN
  localparam int PK = 1;
`else
  localparam int PK = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] in_re = '0;
  logic [N*W-1:0] in_im = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [IW-1:0]  out_idx;
  logic [W-1:0]   out_re;
  logic [W-1:0]   out_im;
  logic [W:0]     out_mag;
  logic           out_last;
  logic           peak_valid;
  logic [IW-1:0]  peak_idx;
  logic [W:0]     peak_mag;
  logic [7:0]     drop_cnt;

  fft_out_serializer #(.N(N), .W(W), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_mag   (out_mag),
    .out_last  (out_last),
    .peak_valid(peak_valid),
    .peak_idx  (peak_idx),
    .peak_mag  (peak_mag),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef struct {
    int           idx;
    logic [W-1:0] re;
    logic [W-1:0] im;
    int           mag;
    bit           last;
  } beat_t;

  beat_t exp_q[$];
  beat_t cur_b;
  bit    pk_pend = 0;
  bit    mon_en = 0;
  int    exp_pk_idx = 0;
  int    exp_pk_mag = 0;
  int    frm_pk_idx = 0;
  int    frm_pk_mag = 0;
  int    exp_drop = 0;
  int    cyc = 0;
  int    cap_times[$];

  task automatic model_capture(input logic [N*W-1:0] re, input logic [N*W-1:0] im);
    int r, i, m;
    beat_t b;
    for (int k = 0; k < N; k++) begin
      r = $signed(re[k*W +: W]);
      i = $signed(im[k*W +: W]);
      m = (r < 0 ? -r : r) + (i < 0 ? -i : i);
      b.idx = k; b.re = re[k*W +: W]; b.im = im[k*W +: W]; b.mag = m; b.last = (k == N - 1);
      exp_q.push_back(b);
      if (k == 0 || m > frm_pk_mag) begin
        frm_pk_idx = k;
        frm_pk_mag = m;
      end
    end
  endtask

  // Outputs/inputs sampled mid-cycle; model advances to the state after the next edge.
  always @(negedge clk) begin
    bit busy;
    cyc++;
    if (rst) begin
      exp_q.delete();
      pk_pend = 0; exp_pk_idx = 0; exp_pk_mag = 0; exp_drop = 0; mon_en = 1;
    end else if (mon_en) begin
      busy = (exp_q.size() != 0) || pk_pend;
      chk("in_ready", 64'(in_ready), 64'(!busy));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      chk("peak_valid", 64'(peak_valid), 64'(pk_pend));
      chk("peak_idx", 64'(peak_idx), 64'(exp_pk_idx));
      chk("peak_mag", 64'(peak_mag), 64'(exp_pk_mag));
      if (exp_q.size() != 0) begin
        chk("out_idx", 64'(out_idx), 64'(exp_q[0].idx));
        chk("out_re", 64'(out_re), 64'(exp_q[0].re));
        chk("out_im", 64'(out_im), 64'(exp_q[0].im));
        chk("out_mag", 64'(out_mag), 64'(exp_q[0].mag));
        chk("out_last", 64'(out_last), 64'(exp_q[0].last));
      end
      if (in_valid && in_ready) cap_times.push_back(cyc);
      pk_pend = 0;
      if (exp_q.size() != 0 && out_ready) begin
        cur_b = exp_q.pop_front();
        if (cur_b.last && PK == 1) begin
          pk_pend = 1; exp_pk_idx = frm_pk_idx; exp_pk_mag = frm_pk_mag;
        end
      end
      if (in_valid) begin
        if (!busy) model_capture(in_re, in_im);
        else if (exp_drop < 255) exp_drop++;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  bit       rdy_rand = 0;
  logic [3:0] rdy_pat = 4'hF;
  int       rdy_ph = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
      else out_ready = rdy_pat[rdy_ph];
      rdy_ph = (rdy_ph + 1) % 4;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic frame_of(input int kind, output logic [N*W-1:0] re, output logic [N*W-1:0] im);
    re = '0; im = '0;
    for (int k = 0; k < N; k++) begin
      case (kind)
        0: re[k*W +: W] = 16'h0400;
        1: if (k == 7) begin re[k*W +: W] = 16'h8000; im[k*W +: W] = 16'h8000; end
        2: begin re[k*W +: W] = 16'(k); im[k*W +: W] = 16'(-k); end
        default: begin re[k*W +: W] = 16'hFFFF; im[k*W +: W] = 16'h7FFF; end
      endcase
    end
  endtask

  function automatic logic [W-1:0] rand_comp();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_frame(output logic [N*W-1:0] re, output logic [N*W-1:0] im);
    for (int k = 0; k < N; k++) begin
      re[k*W +: W] = rand_comp();
      im[k*W +: W] = rand_comp();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    in_valid = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!in_ready && n < 500);
    chk("ready_timeout", 64'(in_ready), 64'(1));
  endtask

  task automatic run_frame(input logic [N*W-1:0] re, input logic [N*W-1:0] im, input int probe,
                           input int probe_mag, input int pidx, input int pmag);
    int  beats = 0;
    int  n = 0;
    bit  done = 0;
    wait_ready();
    in_re = re; in_im = im; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    while (!done && n < 1000) begin
      @(negedge clk); n++;
      if (out_valid && out_ready) begin
        beats++;
        if (int'(out_idx) == probe) chk("tbl_probe_mag", 64'(out_mag), 64'(probe_mag));
        if (out_last) begin
          chk("tbl_last_idx", 64'(out_idx), 64'(N - 1));
          done = 1;
        end
      end
    end
    chk("tbl_stream_done", 64'(done), 64'(1));
    chk("tbl_beats", 64'(beats), 64'(N));
    @(negedge clk);
    chk("tbl_peak_valid", 64'(peak_valid), 64'(PK));
    chk("tbl_peak_idx", 64'(peak_idx), 64'(PK == 1 ? pidx : 0));
    chk("tbl_peak_mag", 64'(peak_mag), 64'(PK == 1 ? pmag : 0));
  endtask

  typedef struct {
    int         kind;
    logic [3:0] pat;
    int         probe;
    int         probe_mag;
    int         pk_idx;
    int         pk_mag;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [N*W-1:0] fr, fi;
    int n;
    vt[0] = '{kind: 0, pat: 4'b1111, probe: 31, probe_mag: 'h400,   pk_idx: 0,  pk_mag: 'h400};
    vt[1] = '{kind: 1, pat: 4'b1111, probe: 7,  probe_mag: 'h10000, pk_idx: 7,  pk_mag: 'h10000};
    vt[2] = '{kind: 0, pat: 4'b1001, probe: 5,  probe_mag: 'h400,   pk_idx: 0,  pk_mag: 'h400};
    vt[3] = '{kind: 2, pat: 4'b0101, probe: 31, probe_mag: 62,      pk_idx: 31, pk_mag: 62};
    vt[4] = '{kind: 3, pat: 4'b0110, probe: 12, probe_mag: 'h8000,  pk_idx: 0,  pk_mag: 'h8000};

    do_reset();
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_idx", 64'(out_idx), 64'(0));

    foreach (vt[v]) begin
      rdy_pat = vt[v].pat;
      frame_of(vt[v].kind, fr, fi);
      run_frame(fr, fi, vt[v].probe, vt[v].probe_mag, vt[v].pk_idx, vt[v].pk_mag);
    end

    // Random traffic: offered frames land in any state, consumer stalls randomly.
    rdy_rand = 1;
    repeat (3000) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 9) == 0);
      rand_frame(fr, fi);
      in_re = fr; in_im = fi;
    end
    in_valid = 0;
    wait_ready();
    rdy_rand = 0;

    // Drop counter saturation while the consumer is stalled.
    do_reset();
    rdy_pat = 4'h0;
    frame_of(2, fr, fi);
    in_re = fr; in_im = fi; in_valid = 1;
    repeat (300) begin @(posedge clk); #1; end
    in_valid = 0;
    chk("sat_drop_cnt", 64'(drop_cnt), 64'(255));
    rdy_pat = 4'hF;
    wait_ready();
    chk("sat_drop_hold", 64'(drop_cnt), 64'(255));

    // Reset while beat 10 is presented.
    do_reset();
    frame_of(2, fr, fi);
    in_re = fr; in_im = fi; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    n = 0;
    while (!(out_valid && out_idx == 5'd9) && n < 100) begin @(negedge clk); n++; end
    chk("mid_rst_reach", 64'(out_idx), 64'(9));
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_drop", 64'(drop_cnt), 64'(0));
    chk("mid_rst_peak_valid", 64'(peak_valid), 64'(0));
    chk("mid_rst_out_idx", 64'(out_idx), 64'(0));
    chk("mid_rst_peak_idx", 64'(peak_idx), 64'(0));
    chk("mid_rst_peak_mag", 64'(peak_mag), 64'(0));
    rst = 0;
    frame_of(0, fr, fi);
    run_frame(fr, fi, 0, 'h400, 0, 'h400);

    // Back-to-back frames with in_valid held high.
    do_reset();
    rdy_pat = 4'hF;
    cap_times.delete();
    rand_frame(fr, fi);
    in_re = fr; in_im = fi; in_valid = 1;
    repeat (4 * (N + 2) + 6) begin @(posedge clk); #1; end
    in_valid = 0;
    chk("b2b_captures", 64'(cap_times.size() >= 4), 64'(1));
    for (int i = 1; i < 4 && i < cap_times.size(); i++) begin
      chk("b2b_period", 64'(cap_times[i] - cap_times[i-1]), 64'(N + 1 + PK));
    end
    wait_ready();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
